div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider that executes the RV32M division ops DIV, DIVU, REM and REMU.
- Sits beside the combinational ALU in the execute stage. The issue logic hands it division-class ops over a valid/ready request channel and collects the result over a valid/ready response channel.
- Uses the same 5-bit op codes the ALU decodes, so the issue logic routes ops 01110..10001 here unchanged.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- op_i  in  5  op code: 01110 div, 01111 divu, 10000 rem, 10001 remu.
- a_i  in  DATA_WIDTH  dividend.
- b_i  in  DATA_WIDTH  divisor.
- flush_i  in  1  abort any in-flight operation.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  consumer takes the result.
- res_o  out  DATA_WIDTH  quotient or remainder.
- dz_o  out  1  divide-by-zero flag (qualified by resp_valid_o).
- of_o  out  1  signed overflow flag (qualified by resp_valid_o).

Behaviour:
- Reset values: req_ready_o=1, resp_valid_o=0, res_o=0, dz_o=0, of_o=0. All internal registers cleared and state=IDLE.
- Reset asserted mid-operation aborts immediately; no response is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - req_ready_o=1.
  - Request accepted on a cycle with req_valid_i && req_ready_o. Latch op, sign flags, |a|, |b|; clear remainder; count=0.
  - Signed ops (div, rem) take absolute values. Unsigned ops use operands raw.
  - Special cases skip CALC and go straight to DONE, giving resp_valid_o one cycle after acceptance:
    - b==0: div/divu res=all-ones, rem/remu res=a_i, dz_o=1.
    - Signed div/rem with a==-2^(DATA_WIDTH-1), b==-1: div res=a_i, rem res=0, of_o=1.
    - Op outside 01110..10001: res=0, no flags.
  - Otherwise go to CALC.
- CALC:
  - req_ready_o=0.
  - One restoring step per cycle: shift {rem,quot} left by 1, trial-subtract |b|. If non-negative, keep the difference and set quotient LSB=1.
  - count increments. After DATA_WIDTH steps, go to FIX.
- FIX (one cycle):
  - Quotient is negated if sign(a)!=sign(b) for div.
  - Remainder is negated if sign(a)=1 for rem.
  - Select quotient (div/divu) or remainder (rem/remu) into res_o. Go to DONE.
- Latency: normal ops give resp_valid_o DATA_WIDTH+2 cycles after the acceptance edge (34 for 32-bit).
- DONE:
  - resp_valid_o=1; res_o/dz_o/of_o held stable until resp_valid_o && resp_ready_i.
  - After the handshake edge: go to IDLE, resp_valid_o=0, dz_o/of_o=0.
  - req_ready_o=0 in DONE, so no overlap of response and new request.
- flush_i:
  - In CALC/FIX/DONE, the state is IDLE on the next edge and resp_valid_o=0; the result is discarded.
  - In IDLE, flush_i has priority over req_valid_i (no acceptance).
- Operands on a_i/b_i/op_i are don't-care after the acceptance cycle.
- Width rules: remainder register DATA_WIDTH+1 bits for the trial subtraction. Results truncated to DATA_WIDTH.
- Semantics are RISC-V: truncating division; the remainder takes the sign of the dividend.

Decomposition:
- Shared package holds:
  - op code constants OP_DIV=01110, OP_DIVU=01111, OP_REM=10000, OP_REMU=10001, so ALU and divider share one source.
  - state enum {IDLE, CALC, FIX, DONE}.
- One natural sub-module: div_step, a combinational single restoring iteration. Inputs rem, quot, divisor; outputs next rem, next quot.

Test Plan:
- divu a=100 b=7, resp_ready_i=1 -> resp_valid_o at cycle 34, res_o=14; remu same operands -> res_o=2; dz_o=of_o=0.
- div a=-7 (0xFFFFFFF9) b=2 -> res_o=0xFFFFFFFD (-3); rem same operands -> res_o=0xFFFFFFFF (-1); rem a=7 b=-2 -> res_o=1.
- divu a=5 b=0 -> resp_valid_o 1 cycle after accept, res_o=0xFFFFFFFF, dz_o=1; rem a=5 b=0 -> res_o=5, dz_o=1.
- div a=0x80000000 b=0xFFFFFFFF -> res_o=0x80000000, of_o=1, 1-cycle latency; rem same operands -> res_o=0, of_o=1.
- Backpressure: resp_ready_i low for 5 cycles after resp_valid_o rises -> res_o stable, req_ready_o=0; handshake -> req_ready_o=1 on the next cycle; a back-to-back request is then accepted.
- flush_i pulsed 10 cycles into CALC -> IDLE next cycle, no resp_valid_o. Separately, rst_n low mid-CALC -> outputs at reset values immediately. Next divu 9/3 -> res_o=3.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared op codes and divider state encoding.
// Imported by the ALU decode and the divider.
package div_unit_pkg;

  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_DIVU = 5'b01111;
  localparam logic [4:0] OP_REM  = 5'b10000;
  localparam logic [4:0] OP_REMU = 5'b10001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic logic op_is_signed(
    input logic [4:0] op
  );
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_quot(
    input logic [4:0] op
  );
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_valid(
    input logic [4:0] op
  );
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration.
// Shift {rem,quot} left, trial-subtract the divisor.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic [DATA_WIDTH-1:0] quot_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic [DATA_WIDTH-1:0] quot_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i[DATA_WIDTH-1:0],
               quot_i[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[DATA_WIDTH]) begin
      rem_o  = diff;
      quot_o = {quot_i[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = shifted;
      quot_o = {quot_i[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU with valid/ready request and response.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [4:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  dz_o,
  output logic                  of_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_NEG =
    {1'b1, {(W-1){1'b0}}};

  state_e        state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [W-1:0]  dvsr_q, dvsr_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          dz_q, dz_d;
  logic          of_q, of_d;

  logic [W:0]    step_rem;
  logic [W-1:0]  step_quot;

  div_step #(
    .DATA_WIDTH(W)
  ) u_step (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  logic         sgn, is_q, sa, sb;
  logic [W-1:0] abs_a, abs_b;
  logic [W-1:0] fix_q, fix_r;

  always_comb begin
    sgn   = op_is_signed(op_i);
    is_q  = op_is_quot(op_i);
    sa    = sgn & a_i[W-1];
    sb    = sgn & b_i[W-1];
    abs_a = sa ? -a_i : a_i;
    abs_b = sb ? -b_i : b_i;
    fix_q = qneg_q ? -quot_q : quot_q;
    fix_r = rneg_q ? -rem_q[W-1:0]
                   : rem_q[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dvsr_d  = dvsr_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    of_d    = of_q;

    unique case (state_q)
      IDLE: begin
        // flush wins over a same-cycle request
        if (req_valid_i && !flush_i) begin
          op_d   = op_i;
          qneg_d = is_q & (sa ^ sb);
          rneg_d = ~is_q & sa;
          dvsr_d = abs_b;
          quot_d = abs_a;
          rem_d  = '0;
          cnt_d  = '0;
          dz_d   = 1'b0;
          of_d   = 1'b0;
          if (!op_is_valid(op_i)) begin
            res_d   = '0;
            state_d = DONE;
          end else if (b_i == '0) begin
            res_d   = is_q ? '1 : a_i;
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (sgn && a_i == MIN_NEG &&
                       b_i == '1) begin
            res_d   = is_q ? a_i : '0;
            of_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = FIX;
        end
        if (flush_i) begin
          state_d = IDLE;
        end
      end
      FIX: begin
        res_d   = op_is_quot(op_q) ? fix_q
                                   : fix_r;
        state_d = flush_i ? IDLE : DONE;
      end
      DONE: begin
        if (flush_i || resp_ready_i) begin
          state_d = IDLE;
          dz_d    = 1'b0;
          of_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      of_q    <= of_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign res_o        = res_q;
  assign dz_o         = dz_q;
  assign of_o         = of_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Latency counts edges from the acceptance edge inclusive.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid_i = 0;
  logic        req_ready_o;
  logic [4:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 0;
  logic        resp_valid_o;
  logic        resp_ready_i = 0;
  logic [31:0] res_o;
  logic        dz_o;
  logic        of_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .res_o       (res_o),
    .dz_o        (dz_o),
    .of_o        (of_o)
  );

  // Issue one request with resp_ready_i=1; report latency and result.
  task automatic do_op(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic [31:0] res,
    output logic        dz,
    output logic        of
  );
    @(negedge clk);
    op_i = op; a_i = a; b_i = b;
    req_valid_i = 1; resp_ready_i = 1;
    @(posedge clk); #1;
    req_valid_i = 0;
    a_i = 32'hDEADBEEF; b_i = 32'h0;
    lat = 1;
    while (!resp_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid_o) lat = -1;
    res = res_o; dz = dz_o; of = of_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready_o, resp_valid_o, res_o,
         dz_o, of_o} !== {1'b1, 1'b0, 32'h0,
                          1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: rdy=%b vld=%b res=%h dz=%b of=%b, want 1 0 0 0 0",
               req_ready_o, resp_valid_o, res_o,
               dz_o, of_o);
    end
  endtask

  task automatic test_normal();
    int lat; logic [31:0] r; logic dz, of;
    logic [4:0]  ops [8];
    logic [31:0] as  [8];
    logic [31:0] bs  [8];
    logic [31:0] exp [8];
    ops = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM,
            OP_REM, OP_DIVU, OP_DIV, OP_REM};
    as  = '{32'd100, 32'd100, 32'hFFFFFFF9,
            32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF,
            32'hFFFFFF9C, 32'hFFFFFF9C};
    bs  = '{32'd7, 32'd7, 32'd2, 32'd2,
            32'hFFFFFFFE, 32'd1, 32'hFFFFFFF9,
            32'hFFFFFFF9};
    exp = '{32'd14, 32'd2, 32'hFFFFFFFD,
            32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
            32'd14, 32'hFFFFFFFE};
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], as[i], bs[i], lat, r, dz, of);
      checks++;
      if (lat !== 34 || r !== exp[i] ||
          dz !== 1'b0 || of !== 1'b0) begin
        fails++;
        $display("FAIL normal[%0d]: lat=%0d res=%h dz=%b of=%b, want lat=34 res=%h dz=0 of=0",
                 i, lat, r, dz, of, exp[i]);
      end
    end
  endtask

  task automatic test_special();
    int lat; logic [31:0] r; logic dz, of;
    logic [4:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic [31:0] exp [5];
    logic [1:0]  fl  [5];
    ops = '{OP_DIVU, OP_REM, OP_DIV, OP_REM,
            5'b00011};
    as  = '{32'd5, 32'd5, 32'h80000000,
            32'h80000000, 32'd9};
    bs  = '{32'd0, 32'd0, 32'hFFFFFFFF,
            32'hFFFFFFFF, 32'd3};
    exp = '{32'hFFFFFFFF, 32'd5, 32'h80000000,
            32'd0, 32'd0};
    fl  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], lat, r, dz, of);
      checks++;
      if (lat !== 1 || r !== exp[i] ||
          {dz, of} !== fl[i]) begin
        fails++;
        $display("FAIL special[%0d]: lat=%0d res=%h dz=%b of=%b, want lat=1 res=%h dz/of=%b",
                 i, lat, r, dz, of, exp[i], fl[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] r, held; logic dz, of;
    int n;
    @(negedge clk);
    op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd10;
    req_valid_i = 1; resp_ready_i = 0;
    @(posedge clk); #1;
    req_valid_i = 0;
    n = 1;
    while (!resp_valid_o && n < 100) begin
      @(posedge clk); #1; n++;
    end
    held = res_o;
    checks++;
    if (n !== 34 || held !== 32'd100) begin
      fails++;
      $display("FAIL bp_first: lat=%0d res=%h, want lat=34 res=00000064",
               n, held);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_o !== 32'd100 || !resp_valid_o ||
          req_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: res=%h vld=%b rdy=%b, want 00000064 1 0",
                 i, res_o, resp_valid_o, req_ready_o);
      end
    end
    @(negedge clk); resp_ready_i = 1;
    @(posedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: rdy=%b vld=%b, want 1 0",
               req_ready_o, resp_valid_o);
    end
    do_op(OP_REMU, 32'd1001, 32'd10, lat, r, dz, of);
    checks++;
    if (lat !== 34 || r !== 32'd1) begin
      fails++;
      $display("FAIL b2b: lat=%0d res=%h, want 34 00000001",
               lat, r);
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    op_i = OP_DIVU; a_i = 32'd77; b_i = 32'd7;
    req_valid_i = 1; resp_ready_i = 1;
    @(posedge clk); #1;
    req_valid_i = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush_i = 1;
    @(posedge clk); #1;
    flush_i = 0;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_calc: rdy=%b vld=%b, want 1 0",
               req_ready_o, resp_valid_o);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid_o) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL flush_noresp: resp cycles=%0d, want 0",
               seen);
    end
    @(negedge clk);
    flush_i = 1; req_valid_i = 1;
    @(posedge clk); #1;
    flush_i = 0; req_valid_i = 0;
    checks++;
    if (req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL flush_idle: rdy=%b, want 1",
               req_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] r; logic dz, of;
    do_op(OP_DIVU, 32'd5, 32'd0, lat, r, dz, of);
    @(negedge clk);
    op_i = OP_DIVU; a_i = 32'd500; b_i = 32'd3;
    req_valid_i = 1; resp_ready_i = 1;
    @(posedge clk); #1;
    req_valid_i = 0;
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({req_ready_o, resp_valid_o, res_o,
         dz_o, of_o} !== {1'b1, 1'b0, 32'h0,
                          1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: rdy=%b vld=%b res=%h dz=%b of=%b, want 1 0 0 0 0",
               req_ready_o, resp_valid_o, res_o,
               dz_o, of_o);
    end
    @(negedge clk); rst_n = 1;
    do_op(OP_DIVU, 32'd9, 32'd3, lat, r, dz, of);
    checks++;
    if (lat !== 34 || r !== 32'd3) begin
      fails++;
      $display("FAIL after_reset: lat=%0d res=%h, want 34 00000003",
               lat, r);
    end
  endtask

  initial begin
    #1;
    test_reset();
    #12 rst_n = 1;
    test_normal();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
